// File: rtl/rr_grant_ctrl.sv
// rr_grant_ctrl: round-robin grant controller for one shared resource.
// Ports: clk, rst (sync, active-high); req/done per requester;
//   gnt (one-hot, registered), gnt_id (owner index), busy (in OWN),
//   timeout (forced-release pulse), state (FSM debug).
module rr_grant_ctrl #(
    parameter  int N_REQ    = 4,
    parameter  int MAX_HOLD = 16,
    localparam int ID_W     = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             busy,
    output logic             timeout,
    output logic [1:0]       state
);

    localparam int CNT_W = $clog2(MAX_HOLD) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ARB  = 2'b01,
        OWN  = 2'b10,
        COOL = 2'b11
    } state_t;

    state_t state_q, state_d;

    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_REQ-1:0] gnt_d;
    logic [ID_W-1:0]  gnt_id_d;
    logic             timeout_d;

    logic             found;
    logic [ID_W-1:0]  winner;
    logic [ID_W-1:0]  ix;

    logic own_done;
    logic own_drop;
    logic at_limit;
    logic release_own;

    // Rotating priority search: first set req bit at or after ptr_q.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        ix     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            int k;
            k = int'(ptr_q) + i;
            if (k >= N_REQ) k = k - N_REQ;
            ix = ID_W'(k);
            if (!found && req[ix]) begin
                found  = 1'b1;
                winner = ix;
            end
        end
    end

    // Release terms; only the owner's done/req bits matter.
    assign own_done    = done[gnt_id];
    assign own_drop    = !req[gnt_id];
    assign at_limit    = (cnt_q == CNT_W'(MAX_HOLD - 1));
    assign release_own = own_done || own_drop || at_limit;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (|req) state_d = ARB;
            ARB:  state_d = found ? OWN : IDLE;
            OWN:  if (release_own) state_d = COOL;
            COOL: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        gnt_d     = gnt;
        gnt_id_d  = gnt_id;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: ;
            ARB: begin
                if (found) begin
                    gnt_d    = N_REQ'(1) << winner;
                    gnt_id_d = winner;
                    cnt_d    = '0;
                end
            end
            OWN: begin
                if (release_own) begin
                    gnt_d     = '0;
                    // done and req-drop outrank the hold limit
                    timeout_d = !own_done && !own_drop;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            COOL: begin
                if (gnt_id == ID_W'(N_REQ - 1)) ptr_d = '0;
                else                             ptr_d = gnt_id + ID_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt     <= '0;
            gnt_id  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            timeout <= 1'b0;
        end else begin
            gnt     <= gnt_d;
            gnt_id  <= gnt_id_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            timeout <= timeout_d;
        end
    end

    assign busy  = (state_q == OWN);
    assign state = state_q;

endmodule
